// File: rtl/uart_rx.sv
// 8N1 UART receiver, OVERSAMPLE ticks per bit, 3-sample majority vote; rx_valid rises 1 clk after stop mid-sample.
// Backpressure: an unaccepted byte is held; a newer byte arriving meanwhile is dropped with an overrun pulse.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_LO   = TW'(M - 1);
  localparam logic [TW-1:0] T_MID  = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   rx_meta;
  logic                   rx_s;
  logic                   samp_a;
  logic                   samp_b;
  logic                   majority;
  logic                   at_decide;
  logic                   deliver;
  logic                   stop_bad;

  assign majority  = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign at_decide = baud_tick && (tick_cnt == T_DEC);
  assign deliver   = at_decide && (state == STOP) && majority;
  assign stop_bad  = at_decide && (state == STOP) && !majority;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      samp_a    <= 1'b0;
      samp_b    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;

      // A same-cycle accept frees the slot, so the new byte replaces the old one.
      if (deliver) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      if (baud_tick) begin
        if (tick_cnt == T_LO)  samp_a <= rx_s;
        if (tick_cnt == T_MID) samp_b <= rx_s;

        case (state)
          IDLE: begin
            // The detecting tick is tick 0 of the start bit, so the next one is tick 1.
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= TW'(1);
            end
          end
          START: begin
            if ((tick_cnt == T_DEC) && majority) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else if (tick_cnt == T_END) begin
              state    <= DATA;
              tick_cnt <= '0;
              bit_cnt  <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          DATA: begin
            if (tick_cnt == T_DEC) shift_reg <= {majority, shift_reg[DATA_BITS-1:1]};
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              if (bit_cnt == B_LAST) state <= STOP;
              else                   bit_cnt <= bit_cnt + BW'(1);
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          STOP: begin
            // Leaving at the decision tick lets the next start edge be caught early.
            if (tick_cnt == T_DEC) begin
              tick_cnt <= '0;
              state    <= majority ? IDLE : WAIT_HI;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
          WAIT_HI: begin
            if (rx_s) state <= IDLE;
          end
          default: begin
            state    <= IDLE;
            tick_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
